fp_addsub: RTL and testbench
============================

FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  in  1  0 = a+b, 1 = a-b; captured with operands.
REQ-007 SHALL have ports a, b  in  W  IEEE-754-style operands.
REQ-008 SHALL have port result  out  W  packed sum/difference.
REQ-009 SHALL have port done  out  1  one-cycle pulse, result valid.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port flags  out  3  {invalid, overflow, underflow}, valid with done.

Function
REQ-012 SHALL implement states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND; each non-IDLE state lasts exactly one cycle.
REQ-013 start high in IDLE at edge N SHALL register a, b, op and enter UNPACK; start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-014 UNPACK SHALL classify operands; op=1 inverts b's sign before classification.
REQ-015 Special cases SHALL complete in UNPACK (done high after edge N+1): NaN input -> canonical qNaN (sign 0, exp all-ones, fraction MSB only); inf-inf of opposite effective sign -> canonical qNaN, invalid=1; single inf -> that inf; zero operand -> other operand; +0 + -0 -> +0; -0 + -0 -> -0.
REQ-016 Subnormal inputs (exp=0, fraction!=0) SHALL be flushed to signed zero before classification.
REQ-017 Normal path: ALIGN SHALL right-shift the smaller-exponent significand (hidden 1 restored) by the exponent difference, capturing guard, round, sticky bits; shifts >= MAN_W+3 leave sticky only.
REQ-018 ADD SHALL add or subtract magnitudes per effective sign, result sign from larger magnitude.
REQ-019 NORM SHALL shift right 1 on carry-out or left to the leading one in a single cycle (priority encoder), adjusting exponent.
REQ-020 Exact cancellation SHALL give +0.
REQ-021 ROUND SHALL round per REQ-030/031, renormalise on rounding carry, pack result, pulse done (high after edge N+5).
REQ-022 Biased exponent >= all-ones after rounding SHALL give signed inf, overflow=1.
REQ-023 Biased exponent <= 0 SHALL give signed zero, underflow=1.
REQ-024 result and flags SHALL hold their value until the next done pulse.
REQ-025 done SHALL never be high for two consecutive cycles; back-to-back start in the cycle after done SHALL be accepted.

Reset
REQ-026 reset SHALL force IDLE, result=0, flags=0, done=0, busy=0 at the next edge.
REQ-027 reset SHALL take priority over start and abort any operation in flight without a done pulse.
REQ-028 Internal datapath registers need no reset value.
REQ-029 After reset deassertion, start SHALL be accepted on the first edge.

Configuration
REQ-030 With FP_ADDSUB_RNE_EN defined, ROUND SHALL apply round-to-nearest, ties-to-even using guard/round/sticky.
REQ-031 Without FP_ADDSUB_RNE_EN, ROUND SHALL truncate (toward zero); guard/round/sticky logic may be removed; latency unchanged.

Verification (W=32 defaults)
REQ-032 a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000, flags 000, done after edge N+5.
REQ-033 a=0xBFC00000, b=0x3F800000, op=0 -> 0xBF000000; a=b=0x3F800000, op=1 -> 0x00000000.
REQ-034 a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, invalid=1, done after edge N+1; a=b=0x7F7FFFFF, op=0 -> 0x7F800000, overflow=1.
REQ-035 a=0x3F800001, b=0x33800000, op=0 -> 0x3F800002 with FP_ADDSUB_RNE_EN, 0x3F800001 without.
REQ-036 start asserted every cycle for 20 cycles with changing operands -> one done per 6 cycles, each result matching the operands captured at acceptance.
REQ-037 reset asserted in ALIGN -> no done pulse, busy=0 and result=0 next cycle, next operation correct.

Source files
------------

// File: rtl/fp_addsub_if.sv
// fp_addsub_if: request/result bundle for the fp_addsub unit.
// master drives start/op/a/b; slave returns result/done/busy/flags.
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic [2:0]   flags;

  modport master (
    output start, op, a, b,
    input  result, done, busy, flags
  );

  modport slave (
    input  start, op, a, b,
    output result, done, busy, flags
  );
endinterface

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754-style adder/subtractor, FSM
// IDLE>UNPACK>ALIGN>ADD>NORM>ROUND; specials finish in UNPACK.
// Ports: clk, reset (sync, active-high), bus (fp_addsub_if.slave):
//   start/op/a/b in; result/done/busy/flags{inv,ovf,unf} out.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; else truncate.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         clk,
  input logic         reset,
  fp_addsub_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int L  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]     a_r, b_r;
  logic             op_r;
  logic             x_s, y_s;
  logic [EXP_W-1:0] x_e, y_e;
  logic [MAN_W:0]   x_m, y_m;
  logic [L-1:0]     xa, ya;
  logic             sub_r, r_s;
  logic [EW-1:0]    r_e;
  logic [L:0]       sum_r;
  logic [L-1:0]     n_r;
  logic [EW-1:0]    ne_r;
  logic             z_r;

  logic [W-1:0]     result_r;
  logic [2:0]       flags_r;
  logic             done_r;

  // Unpack and classify; subnormals flush to signed zero.
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic             a_big;

  assign sa     = a_r[W-1];
  assign sb     = b_r[W-1] ^ op_r;
  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign ma     = (ea == '0) ? '0 : a_r[MAN_W-1:0];
  assign mb     = (eb == '0) ? '0 : b_r[MAN_W-1:0];
  assign nan_a  = (ea == EMAX) && (ma != '0);
  assign nan_b  = (eb == EMAX) && (mb != '0);
  assign inf_a  = (ea == EMAX) && (ma == '0);
  assign inf_b  = (eb == EMAX) && (mb == '0);
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign a_big  = {ea, ma} >= {eb, mb};

  logic         sp;
  logic [W-1:0] sp_res;
  logic [2:0]   sp_fl;

  always_comb begin
    sp     = 1'b1;
    sp_res = '0;
    sp_fl  = '0;
    if (nan_a || nan_b) begin
      sp_res = QNAN;
    end else if (inf_a && inf_b) begin
      if (sa != sb) begin
        sp_res = QNAN;
        sp_fl  = 3'b100;
      end else begin
        sp_res = {sa, EMAX, {MAN_W{1'b0}}};
      end
    end else if (inf_a) begin
      sp_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      sp_res = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (zero_a && zero_b) begin
      sp_res = {sa & sb, {(W-1){1'b0}}};
    end else if (zero_a) begin
      sp_res = {sb, eb, mb};
    end else if (zero_b) begin
      sp_res = {sa, ea, ma};
    end else begin
      sp = 1'b0;
    end
  end

  // Align: shift smaller significand, fold lost bits into sticky.
  logic [EXP_W-1:0] d;
  logic [L-1:0]     y_ext;
  logic [2*L-1:0]   full;
  logic [L-1:0]     ya_nx;

  always_comb begin
    d     = x_e - y_e;
    y_ext = {y_m, 3'b000};
    full  = '0;
    ya_nx = L'(1);
    if (32'(d) < MAN_W + 3) begin
      full  = {y_ext, {L{1'b0}}} >> d;
      ya_nx = {full[2*L-1:L+1], full[L] | (|full[L-1:0])};
    end
  end

  // Normalise: carry shifts right, else leading one to the top.
  int           lead;
  int           sh;
  logic [L-1:0] n_nx;
  logic [EW-1:0] e_nx;

  always_comb begin
    lead = 0;
    for (int i = 0; i < L; i++) begin
      if (sum_r[i]) lead = i;
    end
    sh   = L - 1 - lead;
    n_nx = sum_r[L-1:0];
    e_nx = r_e;
    if (sum_r[L]) begin
      n_nx = {sum_r[L:2], sum_r[1] | sum_r[0]};
      e_nx = r_e + EW'(1);
    end else begin
      n_nx = sum_r[L-1:0] << sh;
      e_nx = r_e - EW'(sh);
    end
  end

  // Round, renormalise on carry, range-check and pack.
  logic [MAN_W:0]   m_rn;
  logic             inc;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0]    re;
  logic [W-1:0]     rn_res;
  logic [2:0]       rn_fl;

  assign m_rn = n_r[L-1:3];

`ifdef FP_ADDSUB_RNE_EN
  assign inc = n_r[2] & (n_r[1] | n_r[0] | m_rn[0]);
`else
  logic unused_grs;
  assign unused_grs = ^n_r[2:0];
  assign inc = 1'b0;
`endif

  always_comb begin
    mr     = {1'b0, m_rn} + {{(MAN_W+1){1'b0}}, inc};
    frac   = mr[MAN_W-1:0];
    re     = ne_r;
    rn_res = '0;
    rn_fl  = '0;
    if (mr[MAN_W+1]) begin
      frac = mr[MAN_W:1];
      re   = ne_r + EW'(1);
    end
    if (z_r) begin
      rn_res = '0;
    end else if (!re[EW-1] && re[EW-2:0] >= {1'b0, EMAX}) begin
      rn_res = {r_s, EMAX, {MAN_W{1'b0}}};
      rn_fl  = 3'b010;
    end else if (re[EW-1] || re == '0) begin
      rn_res = {r_s, {(W-1){1'b0}}};
      rn_fl  = 3'b001;
    end else begin
      rn_res = {r_s, re[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = UNPACK;
      UNPACK:  state_nx = sp ? IDLE : ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_r  <= bus.a;
          b_r  <= bus.b;
          op_r <= bus.op;
        end
      end
      UNPACK: begin
        if (a_big) begin
          x_s <= sa; x_e <= ea; x_m <= {1'b1, ma};
          y_s <= sb; y_e <= eb; y_m <= {1'b1, mb};
        end else begin
          x_s <= sb; x_e <= eb; x_m <= {1'b1, mb};
          y_s <= sa; y_e <= ea; y_m <= {1'b1, ma};
        end
      end
      ALIGN: begin
        xa    <= {x_m, 3'b000};
        ya    <= ya_nx;
        sub_r <= x_s ^ y_s;
        r_s   <= x_s;
        r_e   <= EW'(x_e);
      end
      ADD: begin
        sum_r <= sub_r ? {1'b0, xa} - {1'b0, ya}
                       : {1'b0, xa} + {1'b0, ya};
      end
      NORM: begin
        n_r  <= n_nx;
        ne_r <= e_nx;
        z_r  <= (sum_r == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= '0;
      flags_r  <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == UNPACK && sp) begin
        result_r <= sp_res;
        flags_r  <= sp_fl;
        done_r   <= 1'b1;
      end else if (state == ROUND) begin
        result_r <= rn_res;
        flags_r  <= rn_fl;
        done_r   <= 1'b1;
      end
    end
  end

  assign bus.result = result_r;
  assign bus.flags  = flags_r;
  assign bus.done   = done_r;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_fp_addsub.sv
// tb_fp_addsub: directed vectors and a back-to-back stream,
// scoreboard of expected result/flags/latency for fp_addsub.
module tb_fp_addsub;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_addsub #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  localparam int NV = 16;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          free_edge = 0;
  logic        prev_done = 1'b0;
  logic [31:0] va[NV], vb[NV], vr[NV];
  logic        vop[NV];
  logic [2:0]  vf[NV];
  int          vl[NV];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setv(input int k, input logic [31:0] a,
                      input logic [31:0] b, input logic op,
                      input logic [31:0] r, input logic [2:0] f,
                      input int l);
    va[k] = a; vb[k] = b; vop[k] = op;
    vr[k] = r; vf[k] = f; vl[k] = l;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      chk("done_pulse", {63'd0, prev_done}, 64'd0);
      chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("res%0d", e.id), bus.result, e.r);
        chk($sformatf("flg%0d", e.id), bus.flags, e.f);
        chk($sformatf("lat%0d", e.id), cyc - e.acc, e.lat);
      end
    end
    prev_done <= bus.done;
  end

  task automatic issue(input int k);
    bus.a = va[k];
    bus.b = vb[k];
    bus.op = vop[k];
    bus.start = 1'b1;
    if (cyc + 1 >= free_edge) begin
      sb.push_back('{vr[k], vf[k], cyc + 1, vl[k], k});
      free_edge = cyc + 1 + vl[k] + 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic run(input int k);
    issue(k);
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("busy%0d", k), bus.busy, 1);
    drain();
  endtask

  initial begin
    logic [31:0] r5;
`ifdef FP_ADDSUB_RNE_EN
    r5 = 32'h3F80_0002;
`else
    r5 = 32'h3F80_0001;
`endif
    setv(0,  32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000, 5);
    setv(1,  32'hBFC00000, 32'h3F800000, 0, 32'hBF000000, 3'b000, 5);
    setv(2,  32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000, 5);
    setv(3,  32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 3'b100, 1);
    setv(4,  32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b010, 5);
    setv(5,  32'h3F800001, 32'h33800000, 0, r5,           3'b000, 5);
    setv(6,  32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 3'b000, 1);
    setv(7,  32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 3'b000, 1);
    setv(8,  32'h00000000, 32'h40A00000, 1, 32'hC0A00000, 3'b000, 1);
    setv(9,  32'h00000000, 32'h80000000, 0, 32'h00000000, 3'b000, 1);
    setv(10, 32'h80000000, 32'h00000000, 1, 32'h80000000, 3'b000, 1);
    setv(11, 32'h00000001, 32'h3F800000, 0, 32'h3F800000, 3'b000, 1);
    setv(12, 32'h00800000, 32'h00C00000, 1, 32'h80000000, 3'b001, 5);
    setv(13, 32'h40400000, 32'h40A00000, 0, 32'h41000000, 3'b000, 5);
    setv(14, 32'h3F800000, 32'h00800000, 0, 32'h3F800000, 3'b000, 5);
    setv(15, 32'hFF800000, 32'h7F800000, 0, 32'h7FC00000, 3'b100, 1);

    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    reset = 1'b0;
    free_edge = cyc + 1;

    for (int k = 0; k < NV; k++) run(k);

    bus.a = va[13];
    bus.b = vb[13];
    bus.op = vop[13];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_align", bus.busy, 1);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_flags", bus.flags, 0);
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    free_edge = cyc + 1;
    run(13);

    for (int i = 0; i < 20; i++) begin
      issue((i * 3 + 1) % NV);
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
